// File: rtl/digi_ota_array_if.sv
// Pin-side bundle of the digital OTA array: analog-buffer inputs, controls and pad outputs.
// The block takes the slave view. The tile driver or the bench takes the master view.
interface digi_ota_array_if #(
  parameter int CHANNELS = 4,
  parameter int ACC_W    = 8,
  parameter int HOLD_W   = 4,
  parameter int MON_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic                ena;
  logic [CHANNELS-1:0] vip;
  logic [CHANNELS-1:0] vin;
  logic [CHANNELS-1:0] ch_en;
  logic [3:0]          step;
  logic                leak_en;
  logic [HOLD_W-1:0]   hold_cycles;
  logic                sat_clr;
  logic [MON_W-1:0]    mon_sel;
  logic [CHANNELS-1:0] out;
  logic [CHANNELS-1:0] out_oe;
  logic [CHANNELS-1:0] active;
  logic [CHANNELS-1:0] sat;
  logic [ACC_W-1:0]    acc_mon;

  modport master (
    output ena, vip, vin, ch_en, step, leak_en, hold_cycles, sat_clr, mon_sel,
    input  out, out_oe, active, sat, acc_mon
  );

  modport slave (
    input  ena, vip, vin, ch_en, step, leak_en, hold_cycles, sat_clr, mon_sel,
    output out, out_oe, active, sat, acc_mon
  );
endinterface

// File: rtl/digi_ota_array.sv
// Multi-channel clocked digital OTA: each channel synchronises and majority-filters vip/vin,
// integrates the up/down decision into a saturating accumulator, and drives a sigma-delta bitstream.
module digi_ota_array #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_DEPTH  = 3,
  parameter int ACC_W       = 8,
  parameter int HOLD_W      = 4
) (
  input logic             clk,
  input logic             rst_n,
  digi_ota_array_if.slave bus
);

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_e;

  localparam int HIST_W = (FILT_DEPTH > 1) ? FILT_DEPTH - 1 : 1;

  // Lane 1 carries vip and lane 0 carries vin. The result is 1 when more than half of the window is 1.
  function automatic logic [1:0] majority(input logic [FILT_DEPTH-1:0][1:0] w);
    int n_p;
    int n_n;
    n_p = 0;
    n_n = 0;
    for (int i = 0; i < FILT_DEPTH; i++) begin
      n_p += int'(w[i][1]);
      n_n += int'(w[i][0]);
    end
    return {n_p > FILT_DEPTH / 2, n_n > FILT_DEPTH / 2};
  endfunction

  logic [CHANNELS*ACC_W-1:0] acc_flat;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [SYNC_STAGES-1:0][1:0] sync_q;
    logic [HIST_W-1:0][1:0]      hist_q;
    logic [FILT_DEPTH-1:0][1:0]  win_d;
    logic [1:0]                  filt_q;

    state_e            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  phase_q, phase_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              out_q, out_d;
    logic              sat_q, sat_d;

    logic              up, dn;
    logic [ACC_W:0]    step_ext, sum, mod_sum;
    logic [ACC_W-1:0]  acc_u, clamp;

    // The window is the newest synchronised sample plus FILT_DEPTH-1 older ones,
    // so the filtered bit registers on the same edge the last vote arrives.
    always_comb begin
      win_d[0] = sync_q[SYNC_STAGES-1];
      for (int i = 1; i < FILT_DEPTH; i++) win_d[i] = hist_q[i-1];
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
        hist_q <= '0;
        filt_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], {bus.vip[c], bus.vin[c]}};
        hist_q <= win_d[HIST_W-1:0];
        filt_q <= majority(win_d);
      end
    end

    always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      state_d = state_q;
      acc_d   = acc_q;
      phase_d = phase_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      sat_d   = sat_q;

      up       = filt_q[1] & ~filt_q[0];
      dn       = ~filt_q[1] & filt_q[0];
      step_ext = {{(ACC_W-3){1'b0}}, bus.step};
      sum      = up ? ({acc_q[ACC_W-1], acc_q} + step_ext) : ({acc_q[ACC_W-1], acc_q} - step_ext);
      clamp    = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      acc_u    = {~acc_q[ACC_W-1], acc_q[ACC_W-2:0]};
      mod_sum  = {1'b0, phase_q} + {1'b0, acc_u};

      if (bus.ena) begin
        if (bus.sat_clr) sat_d = 1'b0;
        if (!bus.ch_en[c]) begin
          state_d = IDLE;
          acc_d   = '0;
          phase_d = '0;
          out_d   = 1'b0;
        end else begin
          if (up || dn) begin
            // A sign mismatch between the guard bit and the MSB means the step overflowed.
            if (sum[ACC_W] != sum[ACC_W-1]) begin
              acc_d = clamp;
              sat_d = 1'b1;
            end else begin
              acc_d = sum[ACC_W-1:0];
            end
          end else if (state_q == HOLD && bus.leak_en && acc_q != '0) begin
            acc_d = acc_q[ACC_W-1] ? acc_q + ACC_W'(1) : acc_q - ACC_W'(1);
          end

          unique case (state_q)
            IDLE:  if (up || dn) state_d = TRACK;
            TRACK: if (!(up || dn)) begin
              state_d = HOLD;
              cnt_d   = bus.hold_cycles;
            end
            HOLD: begin
              if (up || dn) state_d = TRACK;
              else if (cnt_q != '0) cnt_d = cnt_q - HOLD_W'(1);
              else begin
                state_d = IDLE;
                acc_d   = '0;
              end
            end
            default: state_d = IDLE;
          endcase

          if (state_d == IDLE) begin
            phase_d = '0;
            out_d   = 1'b0;
          end else begin
            phase_d = mod_sum[ACC_W-1:0];
            out_d   = mod_sum[ACC_W];
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        acc_q   <= '0;
        phase_q <= '0;
        cnt_q   <= '0;
        out_q   <= 1'b0;
        sat_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        acc_q   <= acc_d;
        phase_q <= phase_d;
        cnt_q   <= cnt_d;
        out_q   <= out_d;
        sat_q   <= sat_d;
      end
    end

    assign bus.out[c]    = out_q;
    assign bus.out_oe[c] = (state_q != IDLE);
    assign bus.active[c] = (state_q != IDLE);
    assign bus.sat[c]    = sat_q;
    assign acc_flat[c*ACC_W +: ACC_W] = acc_q;
  end

  always_comb begin
    bus.acc_mon = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(bus.mon_sel) == i) bus.acc_mon = acc_flat[i*ACC_W +: ACC_W];
    end
  end

endmodule

// File: tb/tb_digi_ota_array.sv
// Directed self-checking bench for digi_ota_array: a vector table for channel-0 integration,
// plus hand sequences for reset, latency, glitch, saturation, hold/leak and the control inputs.
module tb_digi_ota_array;
  localparam int CH = 4;
  localparam int AW = 8;
  localparam int HW = 4;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  digi_ota_array_if #(.CHANNELS(CH), .ACC_W(AW), .HOLD_W(HW)) bus ();

  digi_ota_array #(
    .CHANNELS(CH), .SYNC_STAGES(2), .FILT_DEPTH(3), .ACC_W(AW), .HOLD_W(HW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    logic       vip;
    logic       vin;
    logic [3:0] step;
    int         cycles;
    logic [7:0] exp_acc;
    logic       exp_active;
    logic       exp_sat;
  } vec_t;

  vec_t vecs[6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.ena         = 1'b1;
    bus.vip         = '0;
    bus.vin         = '0;
    bus.ch_en       = '1;
    bus.step        = '0;
    bus.leak_en     = 1'b0;
    bus.hold_cycles = '0;
    bus.sat_clr     = 1'b0;
    bus.mon_sel     = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int ones;
    int seen;
    int moved;

    // Channel-0 sequence from reset, hold_cycles=15 and no leak; the expected values allow for the 4-edge filter lag.
    vecs[0] = '{vip: 1'b1, vin: 1'b0, step: 4'd3,  cycles: 10, exp_acc: 8'd18,     exp_active: 1'b1, exp_sat: 1'b0};
    vecs[1] = '{vip: 1'b1, vin: 1'b1, step: 4'd3,  cycles: 6,  exp_acc: 8'd30,     exp_active: 1'b1, exp_sat: 1'b0};
    vecs[2] = '{vip: 1'b0, vin: 1'b1, step: 4'd5,  cycles: 8,  exp_acc: 8'd10,     exp_active: 1'b1, exp_sat: 1'b0};
    vecs[3] = '{vip: 1'b0, vin: 1'b1, step: 4'd15, cycles: 4,  exp_acc: 8'hCE,     exp_active: 1'b1, exp_sat: 1'b0};
    vecs[4] = '{vip: 1'b0, vin: 1'b0, step: 4'd15, cycles: 8,  exp_acc: 8'h92,     exp_active: 1'b1, exp_sat: 1'b0};
    vecs[5] = '{vip: 1'b0, vin: 1'b1, step: 4'd15, cycles: 6,  exp_acc: 8'h80,     exp_active: 1'b1, exp_sat: 1'b1};

    // Reset held while the inputs toggle.
    idle_inputs();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.vip  = 4'(i * 5);
      bus.vin  = 4'(i * 3);
      bus.step = 4'hF;
      tick(1);
    end
    check("rst_out",    32'(bus.out),     32'h0);
    check("rst_oe",     32'(bus.out_oe),  32'h0);
    check("rst_active", 32'(bus.active),  32'h0);
    check("rst_sat",    32'(bus.sat),     32'h0);
    check("rst_acc",    32'(bus.acc_mon), 32'h0);

    // Latency of a stable UP on channel 0.
    apply_reset();
    bus.step   = 4'd1;
    bus.vip[0] = 1'b1;
    tick(4);
    check("lat_oe_e4", 32'(bus.out_oe[0]), 32'h0);
    tick(1);
    check("lat_oe_e5",  32'(bus.out_oe[0]), 32'h1);
    check("lat_acc_e5", 32'(bus.acc_mon),   32'h1);
    tick(1);
    check("lat_acc_e6", 32'(bus.acc_mon), 32'h2);
    tick(1);
    check("lat_acc_e7", 32'(bus.acc_mon), 32'h3);

    // Asynchronous reset mid-TRACK, checked before any clock edge.
    rst_n = 1'b0;
    #2;
    check("arst_oe",     32'(bus.out_oe),  32'h0);
    check("arst_active", 32'(bus.active),  32'h0);
    check("arst_acc",    32'(bus.acc_mon), 32'h0);
    check("arst_out",    32'(bus.out),     32'h0);

    // A single-cycle pulse on vip[1] is rejected by the filter.
    apply_reset();
    bus.mon_sel = 2'd1;
    bus.step    = 4'd1;
    bus.vip     = 4'b0010;
    tick(1);
    bus.vip = '0;
    seen    = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (bus.active[1]) seen = 1;
    end
    check("glitch_active", 32'(seen),        32'h0);
    check("glitch_acc",    32'(bus.acc_mon), 32'h0);

    // Table-driven channel-0 integration.
    apply_reset();
    bus.hold_cycles = 4'd15;
    for (int v = 0; v < 6; v++) begin
      bus.vip[0] = vecs[v].vip;
      bus.vin[0] = vecs[v].vin;
      bus.step   = vecs[v].step;
      tick(vecs[v].cycles);
      check($sformatf("vec%0d_acc", v),    32'(bus.acc_mon),   32'(vecs[v].exp_acc));
      check($sformatf("vec%0d_active", v), 32'(bus.active[0]), 32'(vecs[v].exp_active));
      check($sformatf("vec%0d_sat", v),    32'(bus.sat[0]),    32'(vecs[v].exp_sat));
    end

    // Positive saturation, modulator duty cycle and sticky sat behaviour.
    apply_reset();
    bus.hold_cycles = 4'd15;
    bus.step        = 4'd15;
    bus.vip[0]      = 1'b1;
    tick(20);
    check("sat_acc", 32'(bus.acc_mon), 32'h7F);
    check("sat_set", 32'(bus.sat[0]),  32'h1);
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      tick(1);
      ones += int'(bus.out[0]);
    end
    check("sat_duty", 32'(ones), 32'd255);
    bus.sat_clr = 1'b1;
    tick(1);
    bus.sat_clr = 1'b0;
    check("sat_set_wins", 32'(bus.sat[0]), 32'h1);
    bus.vip[0] = 1'b0;
    tick(8);
    check("sat_sticky", 32'(bus.sat[0]), 32'h1);
    bus.sat_clr = 1'b1;
    tick(1);
    bus.sat_clr = 1'b0;
    check("sat_cleared", 32'(bus.sat[0]), 32'h0);

    // HOLD with leak: acc goes from 10 to 0, then the channel returns to IDLE after 16 HOLD cycles.
    apply_reset();
    bus.step        = 4'd1;
    bus.leak_en     = 1'b1;
    bus.hold_cycles = 4'd15;
    bus.vip[0]      = 1'b1;
    tick(10);
    bus.vip[0] = 1'b0;
    tick(4);
    check("leak_peak", 32'(bus.acc_mon), 32'd10);
    tick(10);
    check("leak_e24", 32'(bus.acc_mon), 32'd1);
    tick(1);
    check("leak_zero", 32'(bus.acc_mon), 32'd0);
    tick(5);
    check("leak_still_hold", 32'(bus.active[0]), 32'h1);
    tick(1);
    check("leak_idle_oe",  32'(bus.out_oe[0]), 32'h0);
    check("leak_idle_out", 32'(bus.out[0]),    32'h0);
    // A fresh run needs a cleared phase to give the known 0,1 start pattern.
    bus.vip[0] = 1'b1;
    tick(5);
    check("phase_clr_e5", 32'(bus.out[0]), 32'h0);
    tick(1);
    check("phase_clr_e6", 32'(bus.out[0]), 32'h1);

    // hold_cycles = 0 gives a single HOLD cycle.
    apply_reset();
    bus.step   = 4'd1;
    bus.vip[0] = 1'b1;
    tick(2);
    bus.vip[0] = 1'b0;
    tick(5);
    check("hold0_in_hold", 32'(bus.active[0]), 32'h1);
    check("hold0_acc",     32'(bus.acc_mon),   32'd2);
    tick(1);
    check("hold0_idle",    32'(bus.active[0]), 32'h0);
    check("hold0_acc_clr", 32'(bus.acc_mon),   32'd0);

    // Per-channel enable and global freeze.
    apply_reset();
    bus.step    = 4'd1;
    bus.vip     = 4'hF;
    bus.mon_sel = 2'd3;
    tick(8);
    check("ctl_acc3", 32'(bus.acc_mon), 32'd4);
    bus.ch_en = 4'b1011;
    tick(1);
    check("ctl_oe",   32'(bus.out_oe), 32'b1011);
    check("ctl_out2", 32'(bus.out[2]), 32'h0);
    bus.mon_sel = 2'd2;
    #1;
    check("ctl_acc2_clr", 32'(bus.acc_mon), 32'd0);
    bus.mon_sel = 2'd1;
    #1;
    check("ctl_acc1", 32'(bus.acc_mon), 32'd5);
    bus.mon_sel = 2'd0;
    tick(1);
    check("ctl_acc0_e10", 32'(bus.acc_mon), 32'd6);
    check("ctl_out0_e10", 32'(bus.out[0]),  32'h1);
    bus.ena = 1'b0;
    moved   = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (bus.acc_mon !== 8'd6 || bus.out[0] !== 1'b1) moved++;
    end
    check("ena_frozen", 32'(moved), 32'h0);
    bus.ena = 1'b1;
    tick(1);
    check("ena_resume_acc", 32'(bus.acc_mon), 32'd7);
    check("ena_resume_out", 32'(bus.out[0]),  32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
